// File: rtl/role_mmio_regs_if.sv
// AXI4-lite bus bundle for the shell-to-role MMIO port (32-bit data).
// The shell side is the master; the role register file is the slave.
interface role_mmio_regs_if #(
    parameter int ADDR_W = 20
);
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/role_mmio_regs.sv
// Control/status register file for the role memory engine, reached over AXI4-lite.
// Holds buffer addresses, length and start control; collects busy/done, a busy-cycle count and irq.
module role_mmio_regs #(
    parameter int ADDR_W     = 20,
    parameter int MEM_ADDR_W = 40
) (
    input  logic                  role_clk,
    input  logic                  role_resetn,
    role_mmio_regs_if.slave       axi_shell_to_role,
    output logic                  eng_start,
    output logic [MEM_ADDR_W-1:0] eng_src_addr,
    output logic [MEM_ADDR_W-1:0] eng_dst_addr,
    output logic [31:0]           eng_len,
    input  logic                  eng_busy,
    input  logic                  eng_done,
    output logic                  irq
);
    localparam int         HI_W        = MEM_ADDR_W - 32;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic              aw_full_q, aw_full_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic              w_full_q, w_full_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              rvalid_q, rvalid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic              irq_en_q, irq_en_d;
    logic              done_q, done_d;
    logic              start_q, start_d;
    logic              irq_q, irq_d;
    logic [31:0]       src_lo_q, src_lo_d;
    logic [HI_W-1:0]   src_hi_q, src_hi_d;
    logic [31:0]       dst_lo_q, dst_lo_d;
    logic [HI_W-1:0]   dst_hi_q, dst_hi_d;
    logic [31:0]       len_q, len_d;
    logic [31:0]       cycles_q, cycles_d;

    logic        awready, wready, arready;
    logic        commit, start_ok;
    logic [31:0] wmask;
    logic [2:0]  wr_idx, rd_idx;
    logic        wr_err, rd_err;
    logic [31:0] rd_mux;

    for (genvar gi = 0; gi < 4; gi++) begin : g_wmask
        assign wmask[gi*8 +: 8] = {8{wstrb_q[gi]}};
    end

    // Channels stall while a response is outstanding so a commit never overlaps a pending B.
    assign awready = !aw_full_q && !bvalid_q;
    assign wready  = !w_full_q && !bvalid_q;
    assign arready = !rvalid_q;
    assign commit  = aw_full_q && w_full_q;

    always_comb begin
        rd_idx = axi_shell_to_role.araddr[4:2];
        rd_err = |axi_shell_to_role.araddr[ADDR_W-1:5];
        rd_mux = '0;
        case (rd_idx)
            3'd0: rd_mux = {30'd0, irq_en_q, 1'b0};
            3'd1: rd_mux = {30'd0, done_q, eng_busy};
            3'd2: rd_mux = src_lo_q;
            3'd3: rd_mux[HI_W-1:0] = src_hi_q;
            3'd4: rd_mux = dst_lo_q;
            3'd5: rd_mux[HI_W-1:0] = dst_hi_q;
            3'd6: rd_mux = len_q;
            default: rd_mux = cycles_q;
        endcase
    end

    always_comb begin
        aw_full_d = aw_full_q;
        awaddr_d  = awaddr_q;
        w_full_d  = w_full_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        irq_en_d  = irq_en_q;
        done_d    = done_q;
        src_lo_d  = src_lo_q;
        src_hi_d  = src_hi_q;
        dst_lo_d  = dst_lo_q;
        dst_hi_d  = dst_hi_q;
        len_d     = len_q;
        cycles_d  = cycles_q;
        start_ok  = 1'b0;
        wr_idx    = awaddr_q[4:2];
        wr_err    = |awaddr_q[ADDR_W-1:5];

        if (axi_shell_to_role.awvalid && awready) begin
            aw_full_d = 1'b1;
            awaddr_d  = axi_shell_to_role.awaddr;
        end
        if (axi_shell_to_role.wvalid && wready) begin
            w_full_d = 1'b1;
            wdata_d  = axi_shell_to_role.wdata;
            wstrb_d  = axi_shell_to_role.wstrb;
        end

        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = wr_err ? RESP_SLVERR : RESP_OKAY;
            if (!wr_err) begin
                case (wr_idx)
                    3'd0: if (wstrb_q[0]) begin
                        irq_en_d = wdata_q[1];
                        start_ok = wdata_q[0] && !eng_busy;
                    end
                    3'd1: if (wstrb_q[0] && wdata_q[1]) done_d = 1'b0;
                    3'd2: src_lo_d = (src_lo_q & ~wmask) | (wdata_q & wmask);
                    3'd3: src_hi_d = (src_hi_q & ~wmask[HI_W-1:0]) | (wdata_q[HI_W-1:0] & wmask[HI_W-1:0]);
                    3'd4: dst_lo_d = (dst_lo_q & ~wmask) | (wdata_q & wmask);
                    3'd5: dst_hi_d = (dst_hi_q & ~wmask[HI_W-1:0]) | (wdata_q[HI_W-1:0] & wmask[HI_W-1:0]);
                    3'd6: len_d = (len_q & ~wmask) | (wdata_q & wmask);
                    default: ;
                endcase
            end
        end else if (bvalid_q && axi_shell_to_role.bready) begin
            bvalid_d = 1'b0;
        end

        if (axi_shell_to_role.arvalid && arready) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_err ? 32'd0 : rd_mux;
            rresp_d  = rd_err ? RESP_SLVERR : RESP_OKAY;
        end else if (rvalid_q && axi_shell_to_role.rready) begin
            rvalid_d = 1'b0;
        end

        // A start can only be accepted while idle, so it never races the busy increment.
        if (start_ok) begin
            cycles_d = '0;
        end else if (eng_busy && cycles_q != 32'hFFFF_FFFF) begin
            cycles_d = cycles_q + 32'd1;
        end

        // Completion is applied after the W1C so a simultaneous set wins.
        if (eng_done) done_d = 1'b1;

        start_d = start_ok;
        irq_d   = done_d && irq_en_d;
    end

    always_ff @(posedge role_clk or negedge role_resetn) begin
        if (!role_resetn) begin
            aw_full_q <= 1'b0;
            awaddr_q  <= '0;
            w_full_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            irq_en_q  <= 1'b0;
            done_q    <= 1'b0;
            start_q   <= 1'b0;
            irq_q     <= 1'b0;
            src_lo_q  <= '0;
            src_hi_q  <= '0;
            dst_lo_q  <= '0;
            dst_hi_q  <= '0;
            len_q     <= '0;
            cycles_q  <= '0;
        end else begin
            aw_full_q <= aw_full_d;
            awaddr_q  <= awaddr_d;
            w_full_q  <= w_full_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            irq_en_q  <= irq_en_d;
            done_q    <= done_d;
            start_q   <= start_d;
            irq_q     <= irq_d;
            src_lo_q  <= src_lo_d;
            src_hi_q  <= src_hi_d;
            dst_lo_q  <= dst_lo_d;
            dst_hi_q  <= dst_hi_d;
            len_q     <= len_d;
            cycles_q  <= cycles_d;
        end
    end

    assign axi_shell_to_role.awready = awready;
    assign axi_shell_to_role.wready  = wready;
    assign axi_shell_to_role.arready = arready;
    assign axi_shell_to_role.bvalid  = bvalid_q;
    assign axi_shell_to_role.bresp   = bresp_q;
    assign axi_shell_to_role.rvalid  = rvalid_q;
    assign axi_shell_to_role.rdata   = rdata_q;
    assign axi_shell_to_role.rresp   = rresp_q;

    assign eng_start    = start_q;
    assign eng_src_addr = {src_hi_q, src_lo_q};
    assign eng_dst_addr = {dst_hi_q, dst_lo_q};
    assign eng_len      = len_q;
    assign irq          = irq_q;

    logic unused_ok;
    assign unused_ok = ^{axi_shell_to_role.awprot, axi_shell_to_role.arprot,
                         awaddr_q[1:0], axi_shell_to_role.araddr[1:0]};
endmodule

// File: tb/tb_role_mmio_regs.sv
// Randomized bench for role_mmio_regs: bus transactions are checked against a
// transaction-level register model; engine pulses and handshakes are counted by monitors.
module tb_role_mmio_regs;
    localparam int ADDR_W = 20;

    logic        role_clk = 1'b0;
    logic        role_resetn;
    logic        eng_start, eng_busy, eng_done, irq;
    logic [39:0] eng_src_addr, eng_dst_addr;
    logic [31:0] eng_len;

    role_mmio_regs_if #(.ADDR_W(ADDR_W)) bus ();

    role_mmio_regs #(.ADDR_W(ADDR_W), .MEM_ADDR_W(40)) dut (
        .role_clk          (role_clk),
        .role_resetn       (role_resetn),
        .axi_shell_to_role (bus),
        .eng_start         (eng_start),
        .eng_src_addr      (eng_src_addr),
        .eng_dst_addr      (eng_dst_addr),
        .eng_len           (eng_len),
        .eng_busy          (eng_busy),
        .eng_done          (eng_done),
        .irq               (irq)
    );

    always #5 role_clk = ~role_clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    // Reference model: register contents as software sees them.
    logic [31:0]     m_reg [8];
    logic            m_irq_en, m_done;
    longint unsigned busy_edges = 0;
    longint unsigned cyc_snap   = 0;
    int n_start_seen = 0, n_start_exp = 0, n_bhs = 0, n_wr = 0;

    always @(posedge role_clk) begin
        if (role_resetn && eng_busy) busy_edges++;
        if (bus.bvalid && bus.bready) n_bhs++;
    end
    always @(negedge role_clk) if (eng_start) n_start_seen++;

    function automatic logic [31:0] exp_cycles();
        longint unsigned d;
        d = busy_edges - cyc_snap;
        return (d > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : d[31:0];
    endfunction

    function automatic logic [33:0] model_read(input logic [19:0] a);
        if (a >= 20'h20) return {2'b10, 32'd0};
        case (a[4:2])
            3'd0:    return {2'b00, 30'd0, m_irq_en, 1'b0};
            3'd1:    return {2'b00, 30'd0, m_done, eng_busy};
            3'd7:    return {2'b00, exp_cycles()};
            default: return {2'b00, m_reg[a[4:2]]};
        endcase
    endfunction

    task automatic model_write(input logic [19:0] a, input logic [31:0] d, input logic [3:0] s,
                               input bit pulse, output logic [1:0] resp, output bit start);
        int idx;
        resp  = 2'b00;
        start = 1'b0;
        idx   = int'(a[4:2]);
        if (a >= 20'h20) resp = 2'b10;
        else if (idx == 0) begin
            if (s[0]) begin
                m_irq_en = d[1];
                start    = d[0] && !eng_busy;
            end
        end else if (idx == 1) begin
            if (s[0] && d[1]) m_done = 1'b0;
        end else if (idx != 7) begin
            for (int b = 0; b < 4; b++) if (s[b]) m_reg[idx][8*b +: 8] = d[8*b +: 8];
            if (idx == 3 || idx == 5) m_reg[idx] = m_reg[idx] & 32'h0000_00FF;
        end
        if (pulse) m_done = 1'b1;
        if (start) begin
            cyc_snap = busy_edges;
            n_start_exp++;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = 32'd0;
        m_irq_en = 1'b0;
        m_done   = 1'b0;
        cyc_snap = busy_edges;
    endtask

    task automatic check_outputs();
        check("src_addr", eng_src_addr, {m_reg[3][7:0], m_reg[2]});
        check("dst_addr", eng_dst_addr, {m_reg[5][7:0], m_reg[4]});
        check("len", eng_len, m_reg[6]);
        check("irq", irq, m_done && m_irq_en);
    endtask

    // mode 0: AW and W together; 1: W trails AW by gap; 2: AW trails W by gap.
    task automatic do_write(input logic [19:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int mode, input int gap, input int bdly, input bit pulse);
        int cyc;
        bit aw_done, w_done, aw_take, w_take, exp_start;
        int aw_at, w_at;
        logic [1:0] exp_resp;
        logic start_at_b;
        aw_at = (mode == 2) ? gap : 0;
        w_at  = (mode == 1) ? gap : 0;
        bus.awaddr = a;
        bus.awprot = 3'($urandom);
        bus.wdata  = d;
        bus.wstrb  = s;
        cyc = 0; aw_done = 0; w_done = 0;
        while (!(aw_done && w_done) && cyc < 40) begin
            if (!aw_done && cyc >= aw_at) bus.awvalid = 1'b1;
            if (!w_done && cyc >= w_at) bus.wvalid = 1'b1;
            aw_take = bus.awvalid && bus.awready;
            w_take  = bus.wvalid && bus.wready;
            @(negedge role_clk);
            cyc++;
            if (aw_take) begin bus.awvalid = 1'b0; aw_done = 1'b1; end
            if (w_take)  begin bus.wvalid = 1'b0;  w_done = 1'b1;  end
            if (w_done && !aw_done) check("wready_low", bus.wready, 1'b0);
            if (aw_done && !w_done) check("awready_low", bus.awready, 1'b0);
        end
        check("aw_w_accept", {aw_done, w_done}, 2'b11);
        if (pulse) eng_done = 1'b1;
        cyc = 0;
        while (!bus.bvalid && cyc < 40) begin
            @(negedge role_clk);
            eng_done = 1'b0;
            cyc++;
        end
        eng_done = 1'b0;
        check("b_latency", cyc, 1);
        start_at_b = eng_start;
        model_write(a, d, s, pulse, exp_resp, exp_start);
        $display("WR a=%05h d=%08h s=%h mode=%0d resp=%0d start=%0d", a, d, s, mode, bus.bresp, start_at_b);
        check("bresp", bus.bresp, exp_resp);
        check("start_with_b", start_at_b, exp_start);
        repeat (bdly) begin
            @(negedge role_clk);
            check("bvalid_hold", {bus.bvalid, bus.awready, bus.wready}, 3'b100);
        end
        bus.bready = 1'b1;
        @(negedge role_clk);
        bus.bready = 1'b0;
        check("b_done", {bus.bvalid, bus.awready, bus.wready}, 3'b011);
        n_wr++;
        check_outputs();
    endtask

    task automatic do_read(input logic [19:0] a, input int rdly,
                           output logic [31:0] data, output logic [1:0] resp);
        int cyc;
        logic [33:0] exp;
        bus.araddr  = a;
        bus.arprot  = 3'($urandom);
        bus.arvalid = 1'b1;
        cyc = 0;
        while (!bus.arready && cyc < 40) begin @(negedge role_clk); cyc++; end
        check("arready_wait", cyc < 40, 1'b1);
        exp = model_read(a);
        @(negedge role_clk);
        bus.arvalid = 1'b0;
        data = bus.rdata;
        resp = bus.rresp;
        $display("RD a=%05h d=%08h resp=%0d", a, data, resp);
        check("rvalid_rise", {bus.rvalid, bus.arready}, 2'b10);
        check($sformatf("rdata_%0h", a), data, exp[31:0]);
        check("rresp", resp, exp[33:32]);
        repeat (rdly) begin
            @(negedge role_clk);
            check("r_hold", {bus.rvalid, bus.arready, bus.rdata}, {1'b1, 1'b0, exp[31:0]});
        end
        bus.rready = 1'b1;
        @(negedge role_clk);
        bus.rready = 1'b0;
        check("r_done", {bus.rvalid, bus.arready}, 2'b01);
    endtask

    task automatic pulse_done();
        @(negedge role_clk);
        eng_done = 1'b1;
        @(negedge role_clk);
        eng_done = 1'b0;
        m_done = 1'b1;
        $display("DONE pulse irq=%0d", irq);
        check_outputs();
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  rr;
        logic [19:0] a;
        int op;

        role_resetn = 1'b0;
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        eng_busy = 1'b0;
        eng_done = 1'b0;
        model_reset();
        repeat (3) @(negedge role_clk);
        check("rst_ready", {bus.awready, bus.wready, bus.arready}, 3'b111);
        check("rst_resp", {bus.bvalid, bus.rvalid, bus.bresp, bus.rresp}, 6'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        check("rst_eng", {eng_start, irq, eng_src_addr, eng_dst_addr, eng_len}, 114'd0);
        role_resetn = 1'b1;
        @(negedge role_clk);

        // Address halves, same-cycle AW/W
        do_write(20'h08, 32'h8000_0000, 4'hF, 0, 0, 0, 1'b0);
        do_write(20'h0C, 32'h0000_001A, 4'hF, 0, 0, 0, 1'b0);
        check("src_1a8", eng_src_addr, 40'h1A_8000_0000);
        do_read(20'h0C, 0, rd, rr);
        check("src_hi_read", rd, 32'h0000_001A);

        // W leading AW, partial strobes
        do_write(20'h18, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, 1'b0);
        do_write(20'h18, 32'h1234_5678, 4'h3, 2, 2, 0, 1'b0);
        check("len_merge", eng_len, 32'hFFFF_5678);

        // Start, busy counting, start ignored while busy
        do_write(20'h00, 32'h3, 4'hF, 0, 0, 0, 1'b0);
        check("start_count1", n_start_seen, n_start_exp);
        do_read(20'h1C, 0, rd, rr);
        check("cycles_zero", rd, 32'd0);
        eng_busy = 1'b1;
        repeat (10) @(negedge role_clk);
        eng_busy = 1'b0;
        do_read(20'h1C, 1, rd, rr);
        check("cycles_10", rd, 32'd10);
        eng_busy = 1'b1;
        do_write(20'h00, 32'h3, 4'hF, 1, 1, 0, 1'b0);
        eng_busy = 1'b0;
        check("start_count2", n_start_seen, n_start_exp);
        do_read(20'h1C, 0, rd, rr);

        // Done / irq, set beats same-cycle clear
        pulse_done();
        do_read(20'h04, 0, rd, rr);
        check("status_done", rd, 32'h2);
        do_write(20'h04, 32'h2, 4'hF, 0, 0, 0, 1'b1);
        check("irq_set_wins", irq, 1'b1);
        do_write(20'h04, 32'h2, 4'hF, 0, 0, 0, 1'b0);
        check("irq_cleared", irq, 1'b0);

        // Out-of-range accesses
        do_read(20'h40, 2, rd, rr);
        check("oor_read", {rr, rd}, {2'b10, 32'd0});
        do_write(20'h24, 32'hDEAD_BEEF, 4'hF, 0, 0, 5, 1'b0);

        for (int i = 0; i < 200; i++) begin
            op = $urandom_range(0, 9);
            if ($urandom_range(0, 7) == 0) a = 20'($urandom_range(32'h20, 32'hF_FFFF));
            else a = 20'($urandom_range(0, 31));
            if (op <= 3)
                do_write(a, $urandom, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 3),
                         $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
            else if (op <= 7)
                do_read(a, $urandom_range(0, 3), rd, rr);
            else if (op == 8)
                pulse_done();
            else begin
                @(negedge role_clk);
                eng_busy = 1'b1;
                repeat ($urandom_range(1, 20)) @(negedge role_clk);
                eng_busy = 1'b0;
            end
        end

        // Reset with both responses pending
        @(negedge role_clk);
        check("pre_rst_ready", {bus.awready, bus.wready, bus.arready}, 3'b111);
        bus.awaddr = 20'h10; bus.wdata = 32'hCAFE_F00D; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        bus.araddr = 20'h08; bus.arvalid = 1'b1;
        @(negedge role_clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        @(negedge role_clk);
        check("pre_rst_valid", {bus.bvalid, bus.rvalid}, 2'b11);
        #2 role_resetn = 1'b0;
        #1;
        check("async_rst", {bus.bvalid, bus.rvalid, bus.awready, bus.wready, bus.arready}, 5'b00111);
        check("async_rst_data", {bus.rdata, eng_start, irq, eng_src_addr, eng_dst_addr, eng_len}, 146'd0);
        @(negedge role_clk);
        role_resetn = 1'b1;
        model_reset();
        repeat (3) @(negedge role_clk);
        check("no_resp_after_rst", {bus.bvalid, bus.rvalid}, 2'b00);
        for (int i = 0; i < 8; i++) do_read(20'(i * 4), 0, rd, rr);
        check_outputs();

        check("start_pulses", n_start_seen, n_start_exp);
        check("b_handshakes", n_bhs, n_wr);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
